controle_coprocessador: RTL and testbench
=========================================

CONTROLE_COPROCESSADOR -- requirements
Module: controle_coprocessador

Interface
REQ-001 SHALL have parameter ELEM_W, default 9: element width in bits.
REQ-002 SHALL have parameter N_ELEM, default 25: elements per 5x5 matrix.
REQ-003 SHALL have parameter BASE_RES, default 50: RAM base address of the result matrix.
REQ-004 SHALL have parameter WD_LIMIT, default 255: maximum ALU wait cycles (used only when the watchdog is compiled in).
REQ-005 SHALL have ports in this order (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: request a full operation.
- opcode, in, 3: ALU operation; sampled with start.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: 1-cycle completion pulse.
- erro, out, 1: sticky error flag.
- ram_addr, out, 8: RAM address.
- ram_we, out, 1: RAM write enable.
- ram_wdata, out, ELEM_W: RAM write data.
- ram_rdata, in, ELEM_W: RAM read data; valid 1 cycle after its address.
- alu_start, out, 1: 1-cycle ALU start pulse.
- alu_op, out, 3: latched opcode.
- matriz_a, out, 225: packed matrix A; element k at bits [9k+8:9k].
- matriz_b, out, 225: packed matrix B; same packing as matriz_a.
- alu_result, in, 225: packed ALU result.
- alu_done, in, 1: ALU completion pulse.

Function
REQ-006 SHALL implement the states IDLE, READ, EXEC, WAIT, WRITE, FIM and ERRO.
REQ-007 In IDLE, start=1 SHALL latch opcode into alu_op, clear the counter, and move to READ; start SHALL be ignored in every other state.
REQ-008 In READ, ram_addr SHALL step 0..49, one address per cycle, with ram_we=0.
REQ-009 The word for address k, captured on the following cycle, SHALL go into element k of matriz_a when k<25, and into element k-25 of matriz_b otherwise.
REQ-010 READ SHALL take exactly 51 cycles (50 addresses plus 1 capture) and then move to EXEC.
REQ-011 EXEC SHALL assert alu_start for exactly one cycle and then move to WAIT; matriz_a and matriz_b SHALL hold stable from EXEC until the next READ.
REQ-012 In WAIT, alu_done=1 SHALL latch alu_result internally and move to WRITE.
REQ-013 In WRITE, for i=0..24 on consecutive cycles: ram_we=1, ram_addr=BASE_RES+i, ram_wdata=result element i; this state SHALL last exactly 25 cycles.
REQ-014 FIM SHALL pulse done for one cycle with ram_we=0 and then move to IDLE; start in the FIM cycle SHALL be ignored.
REQ-015 ram_we SHALL be 0 in every state except WRITE.
REQ-016 alu_done seen outside WAIT SHALL be ignored.
REQ-017 Counters SHALL be 6 bits wide; address arithmetic SHALL be 8-bit and SHALL NOT wrap for BASE_RES up to 231.
REQ-018 Total latency from start to done SHALL be 51 + 1 + W + 25 + 1 cycles, where W is the number of WAIT cycles (W >= 1).

Reset
REQ-019 reset=1 SHALL force IDLE at the next edge from any state, including mid-READ and mid-WRITE.
REQ-020 After reset, the following SHALL all be 0: busy, done, erro, ram_we, alu_start, ram_addr, ram_wdata, alu_op, matriz_a, matriz_b, counters.
REQ-021 reset SHALL take priority over start in the same cycle.

Configuration
REQ-022 With ALU_WATCHDOG_EN defined, a WAIT lasting WD_LIMIT cycles without alu_done SHALL move to ERRO and set erro.
REQ-023 ERRO SHALL pulse done for one cycle, perform no RAM writes, and return to IDLE.
REQ-024 erro SHALL stay set until reset or the next accepted start.
REQ-025 Without ALU_WATCHDOG_EN, WAIT SHALL wait indefinitely, the ERRO state SHALL be unreachable, and erro SHALL be constant 0.

Structure
REQ-026 Package coproc_pkg SHALL hold ELEM_W, N_ELEM, the state encoding and the opcode constants.
REQ-027 Address sequencing SHALL be a single sub-module, contador_endereco, providing load, increment and terminal-count outputs.

Verification
REQ-028 RAM[k]=k, opcode=3'b001, ALU returning done after 4 cycles -> matriz_a element 0 = 0 and element 24 = 24; matriz_b element 0 = 25; done exactly 82 cycles after start.
REQ-029 alu_result all elements 9'h1FF -> RAM[50..74] = 9'h1FF, no writes outside 50..74, ram_we high for exactly 25 cycles.
REQ-030 reset asserted on WRITE cycle 10 -> IDLE next cycle, ram_we=0, only RAM[50..59] modified; a later start completes normally.
REQ-031 start pulsed during READ and WAIT -> ignored, alu_op unchanged, a single done.
REQ-032 ALU_WATCHDOG_EN defined, alu_done never asserted -> erro=1 and a done pulse after 255 WAIT cycles, no RAM writes; without the macro -> busy stays 1.
REQ-033 alu_done pulsed in IDLE and during READ -> no state change and no alu_result latch.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor controller.
//   ELEM_W / N_ELEM : element width and elements per 5x5 matrix
//   CNT_W           : width of the address/element counter
//   ST_*            : controller state encoding
//   OP_*            : ALU opcode constants
package coproc_pkg;

    localparam int ELEM_W = 9;
    localparam int N_ELEM = 25;
    localparam int CNT_W  = 6;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_FIM   = 3'd5;
    localparam logic [2:0] ST_ERRO  = 3'd6;

    localparam logic [2:0] OP_SOMA      = 3'b000;
    localparam logic [2:0] OP_SUB       = 3'b001;
    localparam logic [2:0] OP_MULT      = 3'b010;
    localparam logic [2:0] OP_ESCALAR   = 3'b011;
    localparam logic [2:0] OP_TRANSP    = 3'b100;
    localparam logic [2:0] OP_OPOSTA    = 3'b101;
    localparam logic [2:0] OP_DETERM    = 3'b110;

endpackage

// File: rtl/contador_endereco.sv
// Address/element counter used to sequence RAM reads and writes.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val (has priority over inc)
//   inc        : increment by one
//   load_val   : value loaded by load
//   limite     : terminal-count value
//   count      : current count
//   tc         : high while count equals limite
module contador_endereco
    import coproc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] limite,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == limite);

endmodule

// File: rtl/controle_coprocessador.sv
// Coprocessor controller: reads matrices A and B from RAM (addresses 0..49),
// starts the ALU, waits for it, writes the 25-element result back at
// BASE_RES.., then pulses done.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start, opcode        : operation request and ALU opcode
//   busy, done, erro     : status (busy outside IDLE, 1-cycle done, sticky error)
//   ram_addr/we/wdata    : RAM request; ram_rdata valid one cycle after address
//   alu_start, alu_op    : 1-cycle ALU start pulse and latched opcode
//   matriz_a, matriz_b   : packed operands, element k at [9k+8:9k]
//   alu_result, alu_done : packed ALU result and completion pulse
// Optional feature: define ALU_WATCHDOG_EN to abort a WAIT that lasts
// WD_LIMIT cycles into ERRO (sets erro). Without it erro is constant 0.
module controle_coprocessador #(
    parameter int ELEM_W   = coproc_pkg::ELEM_W,
    parameter int N_ELEM   = coproc_pkg::N_ELEM,
    parameter int BASE_RES = 50,
    parameter int WD_LIMIT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               opcode,
    output logic                     busy,
    output logic                     done,
    output logic                     erro,
    output logic [7:0]               ram_addr,
    output logic                     ram_we,
    output logic [ELEM_W-1:0]        ram_wdata,
    input  logic [ELEM_W-1:0]        ram_rdata,
    output logic                     alu_start,
    output logic [2:0]               alu_op,
    output logic [N_ELEM*ELEM_W-1:0] matriz_a,
    output logic [N_ELEM*ELEM_W-1:0] matriz_b,
    input  logic [N_ELEM*ELEM_W-1:0] alu_result,
    input  logic                     alu_done
);
    import coproc_pkg::*;

    logic [2:0]               state_reg, state_next;
    logic [2:0]               alu_op_reg;
    logic [N_ELEM*ELEM_W-1:0] result_reg;
    logic [ELEM_W-1:0]        result_elem [N_ELEM];
    logic                     cnt_load, cnt_inc, cnt_tc;
    logic [CNT_W-1:0]         cnt_limite, cnt;
    logic                     start_ok;
    logic                     wd_expired;

    assign start_ok = (state_reg == ST_IDLE) && start;

    contador_endereco u_contador (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .load_val ('0),
        .limite   (cnt_limite),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_limite = CNT_W'(N_ELEM - 1);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                    cnt_load   = 1'b1;
                end
            end
            ST_READ: begin
                // 2*N_ELEM addresses plus one extra cycle to capture the last word
                cnt_limite = CNT_W'(2 * N_ELEM);
                if (cnt_tc) begin
                    state_next = ST_EXEC;
                    cnt_load   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_EXEC: state_next = ST_WAIT;
            ST_WAIT: begin
                if (alu_done) begin
                    state_next = ST_WRITE;
                    cnt_load   = 1'b1;
                end else if (wd_expired) begin
                    state_next = ST_ERRO;
                end
            end
            ST_WRITE: begin
                if (cnt_tc) begin
                    state_next = ST_FIM;
                    cnt_load   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_FIM:  state_next = ST_IDLE;
            ST_ERRO: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            alu_op_reg <= 3'b000;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                alu_op_reg <= opcode;
            end
            if ((state_reg == ST_WAIT) && alu_done) begin
                result_reg <= alu_result;
            end
        end
    end

    // Operand capture: in READ, ram_rdata holds the word for address cnt-1,
    // so element gi of A lands when cnt==gi+1, of B when cnt==gi+1+N_ELEM.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
            logic [ELEM_W-1:0] a_elem_reg;
            logic [ELEM_W-1:0] b_elem_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_elem_reg <= '0;
                    b_elem_reg <= '0;
                end else if (state_reg == ST_READ) begin
                    if (cnt == CNT_W'(gi + 1)) begin
                        a_elem_reg <= ram_rdata;
                    end
                    if (cnt == CNT_W'(gi + 1 + N_ELEM)) begin
                        b_elem_reg <= ram_rdata;
                    end
                end
            end

            assign matriz_a[gi*ELEM_W +: ELEM_W] = a_elem_reg;
            assign matriz_b[gi*ELEM_W +: ELEM_W] = b_elem_reg;
            assign result_elem[gi]               = result_reg[gi*ELEM_W +: ELEM_W];
        end
    endgenerate

    always_comb begin
        ram_addr  = 8'd0;
        ram_wdata = '0;
        case (state_reg)
            ST_READ:  ram_addr = {2'b00, cnt};
            ST_WRITE: begin
                ram_addr  = 8'(BASE_RES) + {2'b00, cnt};
                ram_wdata = result_elem[cnt[4:0]];
            end
            default: ;
        endcase
    end

    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FIM) || (state_reg == ST_ERRO);
    assign ram_we    = (state_reg == ST_WRITE);
    assign alu_start = (state_reg == ST_EXEC);
    assign alu_op    = alu_op_reg;

`ifdef ALU_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            erro_reg;

    // wd_cnt_reg counts completed WAIT cycles; it expires on the
    // WD_LIMIT-th WAIT cycle without alu_done.
    assign wd_expired = (wd_cnt_reg == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg <= '0;
            erro_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end else begin
                wd_cnt_reg <= '0;
            end
            if (start_ok) begin
                erro_reg <= 1'b0;
            end else if ((state_reg == ST_WAIT) && (state_next == ST_ERRO)) begin
                erro_reg <= 1'b1;
            end
        end
    end

    assign erro = erro_reg;
`else
    logic unused_wd;
    assign unused_wd  = (WD_LIMIT == 0);
    assign wd_expired = 1'b0;
    assign erro       = 1'b0;
`endif

endmodule

// File: tb/tb_controle_coprocessador.sv
// Self-checking bench for controle_coprocessador: RAM and ALU models, a
// per-cycle reference model of the operation timeline, and directed tests.
module tb_controle_coprocessador;

    localparam int EW   = 9;
    localparam int NE   = 25;
    localparam int BASE = 50;
    localparam int WDL  = 255;
    localparam int MW   = EW * NE;

    logic          clk, reset, start;
    logic [2:0]    opcode;
    logic          busy, done, erro, ram_we, alu_start, alu_done;
    logic [7:0]    ram_addr;
    logic [EW-1:0] ram_wdata, ram_rdata;
    logic [2:0]    alu_op;
    logic [MW-1:0] matriz_a, matriz_b, alu_res;
    logic          alu_done_auto, alu_done_force;

    assign alu_done = alu_done_auto | alu_done_force;

    controle_coprocessador #(.ELEM_W(EW), .N_ELEM(NE), .BASE_RES(BASE), .WD_LIMIT(WDL)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .erro(erro),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .alu_start(alu_start), .alu_op(alu_op),
        .matriz_a(matriz_a), .matriz_b(matriz_b),
        .alu_result(alu_res), .alu_done(alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read, synchronous write
    logic [EW-1:0] mem [256];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // ALU: answers alu_delay cycles after alu_start (0 = never answers)
    int alu_delay = 4;
    int alu_cd = 0;
    initial alu_done_auto = 1'b0;
    always begin
        @(negedge clk);
        if (alu_start && alu_delay > 0) alu_cd = alu_delay;
        @(posedge clk);
        #1;
        alu_done_auto = 1'b0;
        if (alu_cd > 0) begin
            alu_cd--;
            if (alu_cd == 0) alu_done_auto = 1'b1;
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model. Timeline relative to the start cycle r=0:
    // r=1..50 read addr r-1, r=51 last capture, r=52 alu_start, WAIT from 53
    // until alu_done at r=d, writes at r=d+1..d+25, done at r=d+26.
    bit            m_armed = 0, m_active = 0, m_erro = 0;
    int            m_t0 = 0, m_d = -1, m_e = -1;
    logic [2:0]    m_op = 3'b000;
    logic [MW-1:0] m_a = '0, m_b = '0, m_res = '0, snap_a = '0, snap_b = '0;

    always @(negedge clk) begin
        int r;
        logic e_busy, e_done, e_we, e_as;
        r = cyc - m_t0;
        e_busy = m_active; e_done = 1'b0; e_we = 1'b0; e_as = 1'b0;
        if (m_active) begin
            if (r == 52) e_as = 1'b1;
            if (m_d >= 0 && r > m_d && r <= m_d + 25) e_we = 1'b1;
            if ((m_d >= 0 && r == m_d + 26) || (m_e >= 0 && r == m_e)) e_done = 1'b1;
        end
        if (m_armed) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("ram_we", ram_we, e_we);
            check("alu_start", alu_start, e_as);
            check("alu_op", alu_op, m_op);
            check("erro", erro, m_erro);
            if (m_active && r >= 1 && r <= 50) check("read_addr", ram_addr, r - 1);
            if (e_we) begin
                check("wr_addr", ram_addr, BASE + r - m_d - 1);
                check("wr_data", ram_wdata, m_res[EW*(r-m_d-1) +: EW]);
            end
            if (!(m_active && r <= 51)) begin
                check("matriz_a", matriz_a, m_a);
                check("matriz_b", matriz_b, m_b);
            end
        end
        if (reset) begin
            m_armed = 1; m_active = 0; m_erro = 0; m_op = 3'b000; m_a = '0; m_b = '0;
        end else if (m_active) begin
            if (r == 51) begin m_a = snap_a; m_b = snap_b; end
            if (r >= 53 && m_d < 0 && m_e < 0) begin
                if (alu_done) begin
                    m_d = r; m_res = alu_res;
                end
`ifdef ALU_WATCHDOG_EN
                else if (r - 52 == WDL) begin
                    m_e = r + 1; m_erro = 1;
                end
`endif
            end
            if (e_done) m_active = 0;
        end else if (start) begin
            m_active = 1; m_t0 = cyc; m_d = -1; m_e = -1; m_op = opcode; m_erro = 0;
            for (int k = 0; k < NE; k++) begin
                snap_a[EW*k +: EW] = mem[k];
                snap_b[EW*k +: EW] = mem[NE + k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation with optional injections at relative cycles r.
    task automatic run_op(input logic [2:0] op, input int delay, input int inj_s1, input int inj_s2,
                          input int inj_d, input int inj_rst, input int stop_r,
                          input logic [MW-1:0] res_pre, input logic [MW-1:0] res_post, input int switch_r,
                          output int lat, output int nwe, output int ndone);
        int t0, r, done_r;
        alu_delay = delay;
        alu_res = res_pre;
        tick();
        start = 1'b1; opcode = op; t0 = cyc;
        lat = -1; nwe = 0; ndone = 0; done_r = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            r = cyc - t0;
            start = (r == inj_s1) || (r == inj_s2);
            opcode = start ? 3'b010 : op;
            reset = (r == inj_rst);
            alu_done_force = (r == inj_d);
            if (r == switch_r) alu_res = res_post;
            if (ram_we) nwe++;
            if (done) begin
                ndone++;
                if (done_r < 0) begin done_r = r; lat = r; end
            end
            if (stop_r > 0 ? (r >= stop_r) : (done_r >= 0 && r >= done_r + 5)) break;
        end
        start = 1'b0; reset = 1'b0; alu_done_force = 1'b0;
    endtask

    function automatic logic [MW-1:0] fill(input int base, input int step);
        logic [MW-1:0] v;
        for (int i = 0; i < NE; i++) v[EW*i +: EW] = EW'(base + step * i);
        return v;
    endfunction

    initial begin
        int lat, nwe, ndone, bad;
        logic [MW-1:0] res_a, res_c, res_d, res_e, garbage;
        reset = 1'b1; start = 1'b0; opcode = 3'b000; alu_res = '0; alu_done_force = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] <= (k < 50) ? EW'(k) : 9'h0AA;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_erro", erro, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_alu_start", alu_start, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_matriz_a", matriz_a, 0);
        check("rst_matriz_b", matriz_b, 0);
        reset = 1'b0;
        tick();

        // Basic operation, RAM[k]=k, ALU answers after 4 cycles
        res_a = fill(7, 3);
        run_op(3'b001, 4, -1, -1, -1, -1, -1, res_a, res_a, -1, lat, nwe, ndone);
        check("a_latency", lat, 82);
        check("a_ndone", ndone, 1);
        check("a_nwe", nwe, 25);
        check("a_mat_a0", matriz_a[8:0], 0);
        check("a_mat_a24", matriz_a[24*EW +: EW], 24);
        check("a_mat_b0", matriz_b[8:0], 25);
        check("a_mat_b24", matriz_b[24*EW +: EW], 49);
        check("a_alu_op", alu_op, 3'b001);
        check("a_ram50", mem[50], 7);
        check("a_ram74", mem[74], 79);
        check("a_ram75", mem[75], 9'h0AA);

        // All-ones result, one WAIT cycle
        run_op(3'b000, 1, -1, -1, -1, -1, -1, fill(9'h1FF, 0), fill(9'h1FF, 0), -1, lat, nwe, ndone);
        check("b_latency", lat, 79);
        check("b_nwe", nwe, 25);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (k < 50) begin if (mem[k] !== EW'(k)) bad++; end
            else if (k < 75) begin if (mem[k] !== 9'h1FF) bad++; end
            else if (mem[k] !== 9'h0AA) bad++;
        end
        check("b_ram_image_errors", bad, 0);

        // Reset on the 10th WRITE cycle (d=54, writes from r=55, 10th at r=64)
        res_c = fill(9'h100, 1);
        run_op(3'b011, 2, -1, -1, -1, 64, 70, res_c, res_c, -1, lat, nwe, ndone);
        check("c_ndone", ndone, 0);
        check("c_nwe", nwe, 10);
        check("c_busy", busy, 0);
        check("c_ram50", mem[50], 9'h100);
        check("c_ram59", mem[59], 9'h109);
        check("c_ram60", mem[60], 9'h1FF);
        check("c_ram74", mem[74], 9'h1FF);
        res_d = fill(9'h040, 1);
        run_op(3'b100, 2, -1, -1, -1, -1, -1, res_d, res_d, -1, lat, nwe, ndone);
        check("c2_latency", lat, 80);
        check("c2_ram60", mem[60], 9'h04A);
        check("c2_ram74", mem[74], 9'h058);

        // Start pulses during READ (r=10) and WAIT (r=55) are ignored
        run_op(3'b101, 6, 10, 55, -1, -1, -1, res_a, res_a, -1, lat, nwe, ndone);
        check("d_latency", lat, 84);
        check("d_ndone", ndone, 1);
        check("d_alu_op", alu_op, 3'b101);

        // Spurious alu_done in IDLE and during READ is ignored
        garbage = fill(9'h0AB, 0);
        alu_res = garbage;
        tick();
        alu_done_force = 1'b1;
        tick();
        alu_done_force = 1'b0;
        tick();
        check("e_idle_busy", busy, 0);
        res_e = fill(9'h080, 1);
        run_op(3'b110, 3, -1, -1, 20, -1, -1, garbage, res_e, 54, lat, nwe, ndone);
        check("e_latency", lat, 81);
        check("e_ram50", mem[50], 9'h080);
        check("e_ram74", mem[74], 9'h098);

        // ALU never answers
`ifdef ALU_WATCHDOG_EN
        run_op(3'b001, 0, -1, -1, -1, -1, -1, res_a, res_a, -1, lat, nwe, ndone);
        check("f_latency", lat, 308);
        check("f_ndone", ndone, 1);
        check("f_nwe", nwe, 0);
        check("f_erro_sticky", erro, 1);
        run_op(3'b001, 1, -1, -1, -1, -1, -1, res_a, res_a, -1, lat, nwe, ndone);
        check("f2_latency", lat, 79);
        check("f2_erro", erro, 0);
`else
        run_op(3'b001, 0, -1, -1, -1, -1, 400, res_a, res_a, -1, lat, nwe, ndone);
        check("f_busy_hung", busy, 1);
        check("f_ndone", ndone, 0);
        check("f_nwe", nwe, 0);
        check("f_erro", erro, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("f_busy_after_rst", busy, 0);
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
